rr_packet_arbiter: RTL and testbench

Registered, packet-locking arbiter for one switch output port: chooses one of IN_N requesting inputs and holds the grant until that input's tail flit is accepted downstream. Successor to the combinational static-priority arbiter. Adds run-time selectable round-robin or static priority, wormhole lock, and an index plus one-hot grant.

---
 rtl/rr_packet_arbiter_pkg.sv | 16 +
 rtl/rotating_priority_picker.sv | 33 +++
 rtl/rr_packet_arbiter.sv | 81 ++++++++
 tb/tb_rr_packet_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/rr_packet_arbiter_pkg.sv
// rtl/rr_packet_arbiter_pkg.sv - shared encodings and grant-width derivation for switch arbiters
`ifndef RR_ARB_GRANT_W
`define RR_ARB_GRANT_W(n) (((n) > 1) ? $clog2(n) : 1)
`endif

package rr_packet_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  localparam logic MODE_STATIC = 1'b0;
  localparam logic MODE_RR     = 1'b1;

endpackage

// File: rtl/rotating_priority_picker.sv
// rtl/rotating_priority_picker.sv - combinational winner pick: round-robin from ptr, or static MSB-first
module rotating_priority_picker
  import rr_packet_arbiter_pkg::*;
#(
  parameter int IN_N = 5,
  localparam int GRANT_W = `RR_ARB_GRANT_W(IN_N)
) (
  input  logic [IN_N-1:0]    req,
  input  logic [GRANT_W-1:0] ptr,
  input  logic               mode,
  output logic [GRANT_W-1:0] winner,
  output logic               winner_vld
);

  logic [IN_N-1:0] rot;

  always_comb begin
    // Doubling the vector lets a plain right shift act as a rotate by ptr.
    rot        = IN_N'({req, req} >> ptr);
    winner     = '0;
    winner_vld = |req;
    if (mode == MODE_RR) begin
      for (int i = IN_N - 1; i >= 0; i--) begin
        if (rot[i]) winner = GRANT_W'((int'(ptr) + i) % IN_N);
      end
    end else begin
      for (int i = 0; i < IN_N; i++) begin
        if (req[i]) winner = GRANT_W'(i);
      end
    end
  end

endmodule

// File: rtl/rr_packet_arbiter.sv
// rtl/rr_packet_arbiter.sv - packet-locking output-port arbiter, round-robin or static priority
module rr_packet_arbiter
  import rr_packet_arbiter_pkg::*;
#(
  parameter int IN_N = 5,
  localparam int GRANT_W = `RR_ARB_GRANT_W(IN_N)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               mode_i,
  input  logic [IN_N-1:0]    req_i,
  input  logic [IN_N-1:0]    tail_i,
  input  logic               ready_i,
  output logic [GRANT_W-1:0] grant_o,
  output logic [IN_N-1:0]    grant_oh_o,
  output logic               grant_vld_o,
  output logic               locked_o,
  output logic               xfer_o
);

  arb_state_e         state_q, state_d;
  logic [GRANT_W-1:0] ptr_q, ptr_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic               mode_q, mode_d;
  logic [GRANT_W-1:0] winner;
  logic               winner_vld;

  rotating_priority_picker #(.IN_N(IN_N)) u_picker (
    .req        (req_i),
    .ptr        (ptr_q),
    .mode       (mode_i),
    .winner     (winner),
    .winner_vld (winner_vld)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      mode_q  <= MODE_STATIC;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      mode_q  <= mode_d;
    end
  end

  assign locked_o    = (state_q == ST_LOCKED);
  assign grant_o     = grant_q;
  assign grant_oh_o  = locked_o ? (IN_N'(1) << grant_q) : '0;
  assign grant_vld_o = locked_o & req_i[grant_q];
  assign xfer_o      = grant_vld_o & ready_i;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (winner_vld) begin
          state_d = ST_LOCKED;
          grant_d = winner;
          mode_d  = mode_i;
        end
      end
      ST_LOCKED: begin
        if (xfer_o && tail_i[grant_q]) begin
          state_d = ST_IDLE;
          // The mode captured at arbitration decides whether the pointer advances.
          if (mode_q == MODE_RR)
            ptr_d = (int'(grant_q) == IN_N - 1) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// tb/tb_rr_packet_arbiter.sv - scoreboard bench with a queue-based reference model for rr_packet_arbiter
module tb_rr_packet_arbiter;

  localparam int N  = 5;
  localparam int GW = 3;

  typedef struct packed {
    logic [GW-1:0] grant;
    logic [N-1:0]  oh;
    logic          vld;
    logic          locked;
    logic          xfer;
  } outs_t;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          mode_i = 1'b0;
  logic [N-1:0]  req_i = '0;
  logic [N-1:0]  tail_i = '0;
  logic          ready_i = 1'b0;
  logic [GW-1:0] grant_o;
  logic [N-1:0]  grant_oh_o;
  logic          grant_vld_o;
  logic          locked_o;
  logic          xfer_o;

  rr_packet_arbiter #(.IN_N(N)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .mode_i      (mode_i),
    .req_i       (req_i),
    .tail_i      (tail_i),
    .ready_i     (ready_i),
    .grant_o     (grant_o),
    .grant_oh_o  (grant_oh_o),
    .grant_vld_o (grant_vld_o),
    .locked_o    (locked_o),
    .xfer_o      (xfer_o)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_pass   = 0;
  outs_t exp_q[$];

  // Reference model state: who owns the port, where the RR search starts.
  bit m_locked = 0;
  int m_owner  = 0;
  int m_ptr    = 0;
  bit m_rr     = 0;

  function automatic outs_t model_outs();
    outs_t o;
    o.grant  = GW'(m_owner);
    o.oh     = m_locked ? N'(1 << m_owner) : '0;
    o.vld    = m_locked && req_i[m_owner];
    o.xfer   = o.vld && ready_i;
    o.locked = m_locked;
    return o;
  endfunction

  function automatic int pick(input logic [N-1:0] r, input bit rr, input int start);
    if (rr) begin
      for (int k = 0; k < N; k++) if (r[(start + k) % N]) return (start + k) % N;
    end else begin
      for (int k = N - 1; k >= 0; k--) if (r[k]) return k;
    end
    return 0;
  endfunction

  task automatic model_edge();
    outs_t o;
    o = model_outs();
    if (rst_i) begin
      m_locked = 0; m_owner = 0; m_ptr = 0; m_rr = 0;
    end else if (!m_locked) begin
      if (req_i != '0) begin
        m_owner  = pick(req_i, mode_i, m_ptr);
        m_rr     = mode_i;
        m_locked = 1;
      end
    end else if (o.xfer && tail_i[m_owner]) begin
      m_locked = 0;
      if (m_rr) m_ptr = (m_owner + 1) % N;
    end
  endtask

  // Apply inputs for one cycle, queue the expected outputs, then cross the clock edge.
  task automatic cyc(input bit r, input bit m, input logic [N-1:0] q,
                     input logic [N-1:0] t, input bit y);
    rst_i = r; mode_i = m; req_i = q; tail_i = t; ready_i = y;
    exp_q.push_back(model_outs());
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_reset_outs();
    n_checks++;
    if (grant_o === '0 && grant_oh_o === '0 && grant_vld_o === 1'b0 &&
        locked_o === 1'b0 && xfer_o === 1'b0)
      n_pass++;
    else
      $display("FAIL reset state @%0t: grant=%0d oh=%b vld=%b locked=%b xfer=%b",
               $time, grant_o, grant_oh_o, grant_vld_o, locked_o, xfer_o);
  endtask

  task automatic wait_locked(input bit m, input logic [N-1:0] q, input int max_cycles);
    int k;
    k = 0;
    do begin
      cyc(0, m, q, 5'b00000, 0);
      k++;
    end while (locked_o !== 1'b1 && k < max_cycles);
    n_checks++;
    if (locked_o === 1'b1) n_pass++;
    else $display("FAIL wait for lock expired after %0d cycles @%0t", max_cycles, $time);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      outs_t e, a;
      e = exp_q.pop_front();
      a = {grant_o, grant_oh_o, grant_vld_o, locked_o, xfer_o};
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL outputs @%0t: got grant=%0d oh=%b vld=%b locked=%b xfer=%b, want grant=%0d oh=%b vld=%b locked=%b xfer=%b",
                    $time, a.grant, a.oh, a.vld, a.locked, a.xfer,
                    e.grant, e.oh, e.vld, e.locked, e.xfer);
    end
  end

  initial begin
    @(posedge clk);
    model_edge();
    #1;
    // Reset state, static priority picks MSB.
    cyc(1, 0, 5'b00000, 5'b00000, 0);
    check_reset_outs();
    cyc(0, 0, 5'b10010, 5'b00000, 0);
    cyc(0, 0, 5'b10010, 5'b00000, 0);
    cyc(0, 0, 5'b10010, 5'b10000, 1);
    cyc(0, 0, 5'b00000, 5'b00000, 0);
    // Round-robin from ptr 0, release advances to 2, then 4 wins.
    cyc(0, 1, 5'b10010, 5'b00000, 0);
    cyc(0, 1, 5'b10010, 5'b00010, 1);
    cyc(0, 1, 5'b10010, 5'b00000, 0);
    cyc(0, 1, 5'b10010, 5'b00000, 0);
    cyc(0, 1, 5'b10010, 5'b10000, 1);
    // Pointer wrapped to 0: 5'b01001 gives 0, then ptr 1.
    cyc(0, 1, 5'b01001, 5'b00000, 0);
    cyc(0, 1, 5'b01001, 5'b00001, 1);
    // Lock on 1, requester drops for 3 cycles while 0 requests.
    cyc(0, 1, 5'b00010, 5'b00000, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 5'b00001, 5'b00010, 1);
    cyc(0, 1, 5'b00011, 5'b00000, 0);
    cyc(0, 1, 5'b00011, 5'b00010, 1);
    // Lock on 2, tail held with ready low for 4 cycles, then release.
    cyc(0, 1, 5'b00100, 5'b00000, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 5'b00100, 5'b00100, 0);
    cyc(0, 1, 5'b00100, 5'b00100, 1);
    cyc(0, 1, 5'b00000, 5'b00000, 0);
    // Reset while locked mid-packet (ptr 3), then RR restarts at 0.
    cyc(0, 1, 5'b01000, 5'b00000, 0);
    cyc(0, 1, 5'b01000, 5'b00000, 1);
    cyc(1, 1, 5'b01000, 5'b00000, 0);
    check_reset_outs();
    wait_locked(1, 5'b00011, 8);
    cyc(0, 1, 5'b00011, 5'b00001, 1);
    cyc(0, 1, 5'b00000, 5'b00000, 0);
    // Randomized traffic with occasional reset and mode flips.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1,
          N'($urandom) & N'($urandom), N'($urandom), $urandom_range(0, 3) != 0);
    end
    cyc(0, 0, 5'b00000, 5'b00000, 0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
